// File: rtl/snake_engine.sv
// Snake game core: segment body, food placement, wall/self collision and game FSM.
// The renderer reads the board through a registered cell-query port.
module snake_engine #(
  parameter int unsigned X_CELLS   = 64,
  parameter int unsigned Y_CELLS   = 48,
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned INIT_LEN  = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int unsigned XW = $clog2(X_CELLS),
  localparam int unsigned YW = $clog2(Y_CELLS),
  localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [7:0]    key_code,
  input  logic          key_valid,
  input  logic [XW-1:0] q_x,
  input  logic [YW-1:0] q_y,
  output logic          q_head,
  output logic          q_body,
  output logic          q_food,
  output logic [1:0]    game_st,
  output logic [LW-1:0] length,
  output logic [15:0]   score
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPause = 2'd2, StOver = 2'd3} state_e;
  typedef enum logic [1:0] {DirUp = 2'd0, DirRight = 2'd1, DirDown = 2'd2, DirLeft = 2'd3} dir_e;

  localparam int          MaxLenI = int'(MAX_LEN);
  localparam int          InitLenI = int'(INIT_LEN);
  localparam logic [XW-1:0] XMax  = XW'(X_CELLS - 1);
  localparam logic [YW-1:0] YMax  = YW'(Y_CELLS - 1);
  localparam logic [XW-1:0] FoodX0 = XW'(3 * X_CELLS / 4);
  localparam logic [YW-1:0] MidY  = YW'(Y_CELLS / 2);
  localparam logic [LW-1:0] InitLen = LW'(INIT_LEN);
  localparam logic [LW-1:0] MaxLen  = LW'(MAX_LEN);

  state_e        st_q, st_d;
  dir_e          dir_q, dir_d, ndir_q, ndir_d;
  logic [LW-1:0] len_q, len_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [XW-1:0] food_x_q, food_x_d;
  logic [YW-1:0] food_y_q, food_y_d;
  logic          placing_q, placing_d;
  logic          pend_q, pend_d;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];
  logic          q_head_q, q_body_q, q_food_q;

  // Candidate head from the pending direction, plus wall, eat and self-hit flags.
  logic [XW-1:0] hx;
  logic [YW-1:0] hy;
  logic          wall, eat, self_hit;
  always_comb begin
    hx   = seg_x_q[0];
    hy   = seg_y_q[0];
    wall = 1'b0;
    unique case (ndir_q)
      DirUp:    begin wall = (seg_y_q[0] == '0);  hy = seg_y_q[0] - YW'(1); end
      DirRight: begin wall = (seg_x_q[0] == XMax); hx = seg_x_q[0] + XW'(1); end
      DirDown:  begin wall = (seg_y_q[0] == YMax); hy = seg_y_q[0] + YW'(1); end
      DirLeft:  begin wall = (seg_x_q[0] == '0);  hx = seg_x_q[0] - XW'(1); end
      default:  wall = 1'b0;
    endcase
    eat      = (hx == food_x_q) && (hy == food_y_q);
    self_hit = 1'b0;
    for (int i = 0; i < MaxLenI; i++) begin
      if (hx == seg_x_q[i] && hy == seg_y_q[i]) begin
        // The tail vacates on a normal step, but stays put when the snake grows.
        if (i + 1 < int'(len_q)) self_hit = 1'b1;
        else if (i + 1 == int'(len_q) && eat) self_hit = 1'b1;
      end
    end
  end

  // Food candidate from the LFSR and body occupancy tests for placement and the query port.
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic          cand_ok, q_head_d, q_body_d, q_food_d;
  always_comb begin
    cand_x   = lfsr_q[XW-1:0];
    cand_y   = lfsr_q[XW+YW-1:XW];
    cand_ok  = (32'(cand_x) < X_CELLS) && (32'(cand_y) < Y_CELLS);
    q_head_d = (st_q != StIdle) && (q_x == seg_x_q[0]) && (q_y == seg_y_q[0]);
    q_body_d = 1'b0;
    q_food_d = (st_q != StIdle) && (q_x == food_x_q) && (q_y == food_y_q);
    for (int i = 0; i < MaxLenI; i++) begin
      if (i < int'(len_q)) begin
        if (cand_x == seg_x_q[i] && cand_y == seg_y_q[i]) cand_ok = 1'b0;
        if (i > 0 && q_x == seg_x_q[i] && q_y == seg_y_q[i]) q_body_d = 1'b1;
      end
    end
    if (st_q == StIdle || q_head_d) q_body_d = 1'b0;
  end

  // Next-state: keys, step, growth and food placement.
  logic key_s, key_esc, key_p, key_r, is_arrow, do_step;
  dir_e arrow_dir;
  always_comb begin
    st_d      = st_q;
    dir_d     = dir_q;
    ndir_d    = ndir_q;
    len_d     = len_q;
    score_d   = score_q;
    food_x_d  = food_x_q;
    food_y_d  = food_y_q;
    placing_d = placing_q;
    pend_d    = pend_q;
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    key_s     = key_valid && (key_code == 8'h1B);
    key_esc   = key_valid && (key_code == 8'h76);
    key_p     = key_valid && (key_code == 8'h4D) && (st_q == StRun);
    key_r     = key_valid && (key_code == 8'h2D) && (st_q == StPause);
    is_arrow  = 1'b1;
    arrow_dir = DirUp;
    case (key_code)
      8'h75:   arrow_dir = DirUp;
      8'h74:   arrow_dir = DirRight;
      8'h72:   arrow_dir = DirDown;
      8'h6B:   arrow_dir = DirLeft;
      default: is_arrow = 1'b0;
    endcase
    do_step = (st_q == StRun) && !placing_q && (tick || pend_q) && !key_p;

    if (key_s || key_esc) begin
      st_d      = key_s ? StRun : StIdle;
      dir_d     = DirRight;
      ndir_d    = DirRight;
      len_d     = InitLen;
      score_d   = '0;
      food_x_d  = FoodX0;
      food_y_d  = MidY;
      placing_d = 1'b0;
      pend_d    = 1'b0;
      for (int i = 0; i < MaxLenI; i++) begin
        seg_x_d[i] = (i < InitLenI) ? XW'(InitLenI - 1 - i) : '0;
        seg_y_d[i] = MidY;
      end
    end else begin
      if (key_p) st_d = StPause;
      if (key_r) st_d = StRun;
      if (placing_q) begin
        if (tick) pend_d = 1'b1;
        if (cand_ok) begin
          food_x_d  = cand_x;
          food_y_d  = cand_y;
          placing_d = 1'b0;
        end
      end
      if (do_step) begin
        pend_d = 1'b0;
        dir_d  = ndir_q;
        if (wall || self_hit) begin
          st_d = StOver;
        end else begin
          for (int i = 1; i < MaxLenI; i++) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = hx;
          seg_y_d[0] = hy;
          if (eat) begin
            if (len_q < MaxLen) len_d = len_q + LW'(1);
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            placing_d = 1'b1;
          end
        end
      end
      // Reversal test uses the direction being committed this cycle.
      if (key_valid && is_arrow && st_q == StRun && arrow_dir != dir_e'(dir_d ^ 2'b10)) begin
        ndir_d = arrow_dir;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= StIdle;
      dir_q     <= DirRight;
      ndir_q    <= DirRight;
      len_q     <= InitLen;
      score_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      food_x_q  <= FoodX0;
      food_y_q  <= MidY;
      placing_q <= 1'b0;
      pend_q    <= 1'b0;
      q_head_q  <= 1'b0;
      q_body_q  <= 1'b0;
      q_food_q  <= 1'b0;
      for (int i = 0; i < MaxLenI; i++) begin
        seg_x_q[i] <= (i < InitLenI) ? XW'(InitLenI - 1 - i) : '0;
        seg_y_q[i] <= MidY;
      end
    end else begin
      st_q      <= st_d;
      dir_q     <= dir_d;
      ndir_q    <= ndir_d;
      len_q     <= len_d;
      score_q   <= score_d;
      lfsr_q    <= lfsr_d;
      food_x_q  <= food_x_d;
      food_y_q  <= food_y_d;
      placing_q <= placing_d;
      pend_q    <= pend_d;
      q_head_q  <= q_head_d;
      q_body_q  <= q_body_d;
      q_food_q  <= q_food_d;
      seg_x_q   <= seg_x_d;
      seg_y_q   <= seg_y_d;
    end
  end

  assign q_head  = q_head_q;
  assign q_body  = q_body_q;
  assign q_food  = q_food_q;
  assign game_st = st_q;
  assign length  = len_q;
  assign score   = score_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench: default 64x48 board (A) and a 12-wide board (B) whose food starts at (9,24).
module tb_snake_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tick_a = 0, kv_a = 0, tick_b = 0, kv_b = 0;
  logic [7:0] kc_a = 0, kc_b = 0;
  logic [5:0] qx_a = 0, qy_a = 0, qy_b = 0;
  logic [3:0] qx_b = 0;
  logic       qh_a, qb_a, qf_a, qh_b, qb_b, qf_b;
  logic [1:0] st_a, st_b;
  logic [5:0] len_a, len_b;
  logic [15:0] sc_a, sc_b;

  snake_engine u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick_a), .key_code(kc_a), .key_valid(kv_a),
    .q_x(qx_a), .q_y(qy_a), .q_head(qh_a), .q_body(qb_a), .q_food(qf_a),
    .game_st(st_a), .length(len_a), .score(sc_a)
  );

  snake_engine #(.X_CELLS(12)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick_b), .key_code(kc_b), .key_valid(kv_b),
    .q_x(qx_b), .q_y(qy_b), .q_head(qh_b), .q_body(qb_b), .q_food(qf_b),
    .game_st(st_b), .length(len_b), .score(sc_b)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pulse of tick and/or a key on DUT A (b=0) or B (b=1).
  task automatic pulse(input bit b, input bit t, input bit k, input logic [7:0] code);
    @(negedge clk);
    if (b) begin tick_b = t; kv_b = k; kc_b = code; end
    else   begin tick_a = t; kv_a = k; kc_a = code; end
    @(negedge clk);
    tick_a = 0; kv_a = 0; tick_b = 0; kv_b = 0;
  endtask

  task automatic key(input bit b, input logic [7:0] code);
    pulse(b, 1'b0, 1'b1, code);
  endtask

  task automatic step(input bit b);
    pulse(b, 1'b1, 1'b0, 8'h00);
    idle(20);
  endtask

  task automatic query(input bit b, input int x, input int y,
                       output logic h, output logic bd, output logic f);
    @(negedge clk);
    if (b) begin qx_b = x[3:0]; qy_b = y[5:0]; end
    else   begin qx_a = x[5:0]; qy_a = y[5:0]; end
    @(negedge clk);
    if (b) begin h = qh_b; bd = qb_b; f = qf_b; end
    else   begin h = qh_a; bd = qb_a; f = qf_a; end
  endtask

  task automatic check_cell(input string tag, input bit b, input int x, input int y,
                            input logic eh, input logic eb, input logic ef);
    logic h, bd, f;
    query(b, x, y, h, bd, f);
    check({tag, ".head"}, {31'd0, h}, {31'd0, eh});
    check({tag, ".body"}, {31'd0, bd}, {31'd0, eb});
    check({tag, ".food"}, {31'd0, f}, {31'd0, ef});
  endtask

  initial begin
    logic h, bd, f;
    int food_cnt, food_bad;

    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    check("rst.st", st_a, 0);
    check("rst.len", len_a, 5);
    check("rst.score", sc_a, 0);
    check_cell("rst.idle_q", 0, 4, 24, 0, 0, 0);

    // 1: start and three steps right
    key(0, 8'h1B);
    check("t1.st_run", st_a, 1);
    repeat (3) step(0);
    check("t1.len", len_a, 5);
    check_cell("t1.head", 0, 7, 24, 1, 0, 0);
    check_cell("t1.tail", 0, 3, 24, 0, 1, 0);
    check_cell("t1.past_tail", 0, 2, 24, 0, 0, 0);
    check_cell("t1.food", 0, 48, 24, 0, 0, 1);

    // 2: reversal ignored, up then left before a tick keeps heading up
    key(0, 8'h6B);
    step(0);
    check_cell("t2.rev_ignored", 0, 8, 24, 1, 0, 0);
    key(0, 8'h75);
    key(0, 8'h6B);
    step(0);
    step(0);
    check_cell("t2.up2", 0, 8, 22, 1, 0, 0);

    // 3: narrow board, food at (9,24) eaten after five steps
    key(1, 8'h1B);
    check_cell("t3.food0", 1, 9, 24, 0, 0, 1);
    repeat (4) step(1);
    pulse(1, 1'b1, 1'b0, 8'h00);
    check("t3.len", len_b, 6);
    check("t3.score", sc_b, 1);
    idle(64);
    food_cnt = 0;
    food_bad = 0;
    for (int x = 0; x < 12; x++) begin
      for (int y = 0; y < 48; y++) begin
        query(1, x, y, h, bd, f);
        if (f) begin
          food_cnt++;
          if (h || bd) food_bad++;
        end
      end
    end
    check("t3.food_count", food_cnt, 1);
    check("t3.food_offbody", food_bad, 0);

    // 5: tail-chase is legal, turning into the body is not
    key(1, 8'h75); step(1);
    key(1, 8'h6B); step(1); step(1);
    key(1, 8'h72); step(1);
    check("t5.tail_ok_st", st_b, 1);
    check_cell("t5.tail_head", 1, 7, 24, 1, 0, 0);
    key(1, 8'h74); step(1);
    check("t5.tail_ok2_st", st_b, 1);
    check_cell("t5.tail_head2", 1, 8, 24, 1, 0, 0);
    key(1, 8'h75); step(1);
    check("t5.self_over", st_b, 3);
    check("t5.len", len_b, 6);
    check_cell("t5.frozen", 1, 8, 24, 1, 0, 0);

    // 4: run into the right wall from start
    key(0, 8'h1B);
    check("t4.restart_len", len_a, 5);
    repeat (59) step(0);
    check("t4.st_run", st_a, 1);
    check_cell("t4.edge", 0, 63, 24, 1, 0, 0);
    check("t4.ate", {31'd0, sc_a != 0}, 1);
    step(0);
    check("t4.wall_over", st_a, 3);
    check_cell("t4.frozen", 0, 63, 24, 1, 0, 0);

    // 6: pause holds the body, resume moves, P with tick suppresses the step
    key(0, 8'h1B);
    key(0, 8'h4D);
    check("t6.paused", st_a, 2);
    repeat (10) step(0);
    check_cell("t6.held", 0, 4, 24, 1, 0, 0);
    key(0, 8'h2D);
    check("t6.resumed", st_a, 1);
    step(0);
    check_cell("t6.moved", 0, 5, 24, 1, 0, 0);
    pulse(0, 1'b1, 1'b1, 8'h4D);
    check("t6.p_tick_st", st_a, 2);
    check_cell("t6.p_tick_head", 0, 5, 24, 1, 0, 0);

    // 6: reset while B is placing food
    key(1, 8'h1B);
    repeat (4) step(1);
    pulse(1, 1'b1, 1'b0, 8'h00);
    check("t6.b_len_pre", len_b, 6);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    check("t6.b_st", st_b, 0);
    check("t6.b_len", len_b, 5);
    check("t6.b_score", sc_b, 0);
    check("t6.a_st", st_a, 0);
    key(1, 8'h1B);
    check_cell("t6.b_food", 1, 9, 24, 0, 0, 1);
    check_cell("t6.b_head", 1, 4, 24, 1, 0, 0);
    key(0, 8'h1B);
    check_cell("t6.a_food", 0, 48, 24, 0, 0, 1);
    key(0, 8'h76);
    check("t6.esc_idle", st_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
